// File: rtl/ps_serializer_param.sv
// Parameterised parallel-to-serial shifter with valid/ready input and registered serial output.
// Optional even-parity trailer bit when the macro SER_PARITY_EN is defined.
module ps_serializer_param #(
    parameter int   WIDTH     = 10,
    parameter bit   LSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic             OS,
    output logic             OS_VALID,
    output logic             FRAME_START,
    output logic             BUSY
);

`ifdef SER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CW = $clog2(FL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FL - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             os_q, os_d;
    logic             os_valid_q, os_valid_d;
    logic             fs_q, fs_d;
    logic             first_bit, next_bit;
    logic             last, load;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // next_bit is the bit that follows the one currently on OS, taken before the shift.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign first_bit = D[0];
            assign next_bit  = sr_q[1];
            assign sr_shift  = {IDLE_BIT, sr_q[WIDTH-1:1]};
        end else begin : g_msb
            assign first_bit = D[WIDTH-1];
            assign next_bit  = sr_q[WIDTH-2];
            assign sr_shift  = {sr_q[WIDTH-2:0], IDLE_BIT};
        end
    endgenerate

    assign last    = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign D_READY = !RESET && ((state_q == ST_IDLE) || last);
    assign load    = D_VALID && D_READY;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        os_d       = os_q;
        os_valid_d = os_valid_q;
        fs_d       = fs_q;
`ifdef SER_PARITY_EN
        par_d      = par_q;
`endif
        if (load) begin
            state_d    = ST_SHIFT;
            sr_d       = D;
            cnt_d      = '0;
            os_d       = first_bit;
            os_valid_d = 1'b1;
            fs_d       = 1'b1;
`ifdef SER_PARITY_EN
            par_d      = ^D;
`endif
        end else if (last) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            os_d       = IDLE_BIT;
            os_valid_d = 1'b0;
            fs_d       = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + CW'(1);
            fs_d  = 1'b0;
            os_d  = next_bit;
`ifdef SER_PARITY_EN
            if (cnt_q == CW'(WIDTH - 1)) begin
                os_d = par_q;
            end
`endif
        end else begin
            os_d       = IDLE_BIT;
            os_valid_d = 1'b0;
            fs_d       = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            os_q       <= IDLE_BIT;
            os_valid_q <= 1'b0;
            fs_q       <= 1'b0;
`ifdef SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            os_q       <= os_d;
            os_valid_q <= os_valid_d;
            fs_q       <= fs_d;
`ifdef SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign OS          = os_q;
    assign OS_VALID    = os_valid_q;
    assign FRAME_START = fs_q;
    assign BUSY        = (state_q == ST_SHIFT);

endmodule
